// File: rtl/par_to_ser_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial transmitter.
// Optional parity beat is enabled by defining PAR_TO_SER_PARITY_EN.
package par_to_ser_pkg;

   typedef enum logic {IDLE, SHIFT} tx_state_t;

   // Counter must reach BEATS-1 (up to N) without wrapping.
   function automatic int unsigned ctrWidth(input int unsigned n);
      return $clog2(n + 2);
   endfunction

`ifdef PAR_TO_SER_PARITY_EN
   localparam int unsigned PARITY_BEATS = 1;
`else
   localparam int unsigned PARITY_BEATS = 0;
`endif

endpackage

// File: rtl/shift_reg_aclr.sv
// Loadable W-bit shift register with zero fill and asynchronous active-high clear.
// dir=0 shifts toward bit 0, dir=1 shifts toward bit W-1.
module shift_reg_aclr
   import par_to_ser_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         aclr,
   input  logic         load,
   input  logic         shift,
   input  logic         dir,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= dir ? (q << 1) : (q >> 1);
      end
   end

endmodule

// File: rtl/par_to_ser_tx.sv
// Parallel-to-serial transmitter: one N-bit word per frame over a valid/ready bit link.
// Define PAR_TO_SER_PARITY_EN to append an even-parity beat after the data bits.
module par_to_ser_tx
   import par_to_ser_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic         clock,
   input  logic         aclr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic         ser_out,
   output logic         ser_last,
   output logic         busy
);

   localparam int unsigned BEATS = N + PARITY_BEATS;
   localparam int unsigned W     = BEATS;
   localparam int unsigned CW    = ctrWidth(N);
   localparam logic [W-1:0] OUT_TAP = (MSB_FIRST != 0) ? (W'(1) << (W - 1)) : W'(1);

   tx_state_t     stateQ, stateNext;
   logic [CW-1:0] cntQ, cntNext;
   logic          lastQ, lastNext;
   logic          readyQ, readyNext;
   logic          validQ, validNext;
   logic          load, shift;
   logic [W-1:0]  loadWord;
   logic [W-1:0]  shiftQ;

`ifdef PAR_TO_SER_PARITY_EN
   // Parity rides in the shift register just behind the last data bit.
   logic parity;
   assign parity   = ^in_data;
   assign loadWord = (MSB_FIRST != 0) ? {in_data, parity} : {parity, in_data};
`else
   assign loadWord = in_data;
`endif

   shift_reg_aclr #(.W(W)) uShift (
      .clock (clock),
      .aclr  (aclr),
      .load  (load),
      .shift (shift),
      .dir   (MSB_FIRST != 0),
      .d     (loadWord),
      .q     (shiftQ)
   );

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         stateQ <= IDLE;
         cntQ   <= '0;
         lastQ  <= 1'b0;
         readyQ <= 1'b1;
         validQ <= 1'b0;
      end else begin
         stateQ <= stateNext;
         cntQ   <= cntNext;
         lastQ  <= lastNext;
         readyQ <= readyNext;
         validQ <= validNext;
      end
   end

   always_comb begin
      stateNext = stateQ;
      cntNext   = cntQ;
      lastNext  = lastQ;
      readyNext = readyQ;
      validNext = validQ;
      load      = 1'b0;
      shift     = 1'b0;
      case (stateQ)
         IDLE: begin
            if (in_valid) begin
               stateNext = SHIFT;
               load      = 1'b1;
               cntNext   = '0;
               lastNext  = (BEATS == 1);
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               shift = 1'b1;
               if (lastQ) begin
                  stateNext = IDLE;
                  cntNext   = '0;
                  lastNext  = 1'b0;
               end else begin
                  cntNext  = cntQ + CW'(1);
                  lastNext = ((cntQ + CW'(1)) == CW'(BEATS - 1));
               end
            end
         end
      endcase
      // Handshake flags track the state being entered.
      readyNext = (stateNext == IDLE);
      validNext = (stateNext == SHIFT);
   end

   // Output-end tap; the mask picks bit 0 or bit W-1.
   assign ser_out   = |(shiftQ & OUT_TAP);
   assign in_ready  = readyQ;
   assign ser_valid = validQ;
   assign busy      = validQ;
   assign ser_last  = lastQ;

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Bench for par_to_ser_tx: three instances (8-bit LSB-first, 8-bit MSB-first, 1-bit)
// checked each cycle against a bit-list reference model.
module tb_par_to_ser_tx;

`ifdef PAR_TO_SER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NI = 3;

   logic       clock = 1'b0;
   logic       aclr;
   logic       in_valid;
   logic [7:0] in_data;
   logic       ser_ready;
   logic [NI-1:0] inReady, serValid, serOut, serLast, busyO;

   int testCount = 0;
   int failCount = 0;

   // Reference: each instance holds the current frame as a bit list in send order.
   int instN   [NI] = '{8, 8, 1};
   int instMsb [NI] = '{0, 1, 0};
   bit expBits [NI][10];
   int expLen  [NI];
   int expPos  [NI];

   always #5 clock = ~clock;

   par_to_ser_tx #(.N(8), .MSB_FIRST(0)) dutLsb (
      .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(inReady[0]),
      .in_data(in_data), .ser_valid(serValid[0]), .ser_ready(ser_ready),
      .ser_out(serOut[0]), .ser_last(serLast[0]), .busy(busyO[0]));

   par_to_ser_tx #(.N(8), .MSB_FIRST(1)) dutMsb (
      .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(inReady[1]),
      .in_data(in_data), .ser_valid(serValid[1]), .ser_ready(ser_ready),
      .ser_out(serOut[1]), .ser_last(serLast[1]), .busy(busyO[1]));

   par_to_ser_tx #(.N(1), .MSB_FIRST(0)) dutOne (
      .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(inReady[2]),
      .in_data(in_data[0]), .ser_valid(serValid[2]), .ser_ready(ser_ready),
      .ser_out(serOut[2]), .ser_last(serLast[2]), .busy(busyO[2]));

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < NI; i++) begin
         expLen[i] = 0;
         expPos[i] = 0;
      end
   endtask

   task automatic loadModel(input int i, input logic [7:0] d);
      int  n;
      bit  par;
      n   = instN[i];
      par = 1'b0;
      for (int k = 0; k < n; k++) begin
         expBits[i][k] = (instMsb[i] != 0) ? d[n - 1 - k] : d[k];
         par ^= d[k];
      end
      if (PB != 0) expBits[i][n] = par;
      expLen[i] = n + PB;
      expPos[i] = 0;
   endtask

   // Model update for one rising edge, from the inputs present at that edge.
   task automatic modelEdge();
      for (int i = 0; i < NI; i++) begin
         if (aclr) begin
            expLen[i] = 0;
            expPos[i] = 0;
         end else if (expPos[i] == expLen[i]) begin
            if (in_valid) loadModel(i, in_data);
         end else if (ser_ready) begin
            expPos[i]++;
         end
      end
   endtask

   task automatic checkOutputs();
      for (int i = 0; i < NI; i++) begin
         bit active;
         active = (expPos[i] < expLen[i]);
         checkEq($sformatf("in_ready[%0d]", i), 32'(inReady[i]), 32'(!active));
         checkEq($sformatf("ser_valid[%0d]", i), 32'(serValid[i]), 32'(active));
         checkEq($sformatf("busy[%0d]", i), 32'(busyO[i]), 32'(active));
         if (active) begin
            checkEq($sformatf("ser_out[%0d] beat %0d", i, expPos[i]), 32'(serOut[i]),
                    32'(expBits[i][expPos[i]]));
            checkEq($sformatf("ser_last[%0d] beat %0d", i, expPos[i]), 32'(serLast[i]),
                    32'(expPos[i] == expLen[i] - 1));
         end else begin
            checkEq($sformatf("ser_last_idle[%0d]", i), 32'(serLast[i]), 32'd0);
         end
      end
   endtask

   task automatic checkResetOuts();
      for (int i = 0; i < NI; i++) begin
         checkEq($sformatf("rst in_ready[%0d]", i), 32'(inReady[i]), 32'd1);
         checkEq($sformatf("rst ser_valid[%0d]", i), 32'(serValid[i]), 32'd0);
         checkEq($sformatf("rst ser_out[%0d]", i), 32'(serOut[i]), 32'd0);
         checkEq($sformatf("rst ser_last[%0d]", i), 32'(serLast[i]), 32'd0);
         checkEq($sformatf("rst busy[%0d]", i), 32'(busyO[i]), 32'd0);
      end
   endtask

   // Entered just after a falling edge with inputs set; leaves at the next falling edge.
   task automatic step();
      #1 checkOutputs();
      @(posedge clock);
      modelEdge();
      @(negedge clock);
   endtask

   initial begin
      aclr      = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      ser_ready = 1'b1;
      clearModel();
      #1 aclr = 1'b1;
      #1 checkResetOuts();
      @(negedge clock);
      repeat (3) step();
      checkResetOuts();

      aclr     = 1'b0;
      in_valid = 1'b0;
      step();

      // Basic frame
      in_valid = 1'b1; in_data = 8'hA5; step();
      in_valid = 1'b0; repeat (10) step();

      // Backpressure after beat 2
      in_valid = 1'b1; in_data = 8'h3C; step();
      in_valid = 1'b0; repeat (2) step();
      ser_ready = 1'b0; repeat (3) step();
      ser_ready = 1'b1; repeat (8) step();

      // New word offered throughout the frame
      in_valid = 1'b1; in_data = 8'h81; step();
      in_data = 8'hFF; repeat (12) step();
      in_valid = 1'b0; repeat (10) step();

      // Reset in mid-frame
      in_valid = 1'b1; in_data = 8'hF0; step();
      in_valid = 1'b0; repeat (4) step();
      aclr = 1'b1;
      clearModel();
      #1 checkResetOuts();
      step();
      aclr = 1'b0; step();
      in_valid = 1'b1; in_data = 8'h01; step();
      in_valid = 1'b0; repeat (11) step();

      // Random traffic with occasional resets
      repeat (3000) begin
         in_valid  = ($urandom_range(0, 2) == 0);
         in_data   = 8'($urandom);
         ser_ready = ($urandom_range(0, 3) != 0);
         aclr      = ($urandom_range(0, 199) == 0);
         if (aclr) clearModel();
         step();
      end
      aclr = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
      repeat (12) step();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/par_to_ser_tx.md
Name: par_to_ser_tx

Overview:
- Transmit-side counterpart to the parallel capture register bank: takes an N-bit parallel word and sends it out one bit per beat over a valid/ready serial link.
- Sits between a producer of parallel words (register bank, test driver) and a serial consumer / capture chain.
- One word is in flight at a time; the block owns the word from acceptance until its last bit is accepted.

Parameters:
- N, 8, data word width in bits (N >= 1).
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit N-1 sent first.

Ports:
- clock  input  1  single clock, all state on rising edge.
- aclr  input  1  asynchronous active-high reset; clears all state immediately.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept a word (high only in IDLE).
- in_data  input  N  parallel word.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  consumer accepts the current bit.
- ser_out  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the frame.
- busy  output  1  frame in progress (state SHIFT).

Behaviour:
- Reset (aclr=1, asynchronous assert): state=IDLE, shift register=0, bit counter=0. Outputs: in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- FSM states: IDLE, SHIFT.
- IDLE: in_ready=1, ser_valid=0. On a clock edge with in_valid=1, load in_data into the shift register, clear the counter and go to SHIFT. in_valid=0 keeps the block in IDLE.
- SHIFT: in_ready=0, busy=1, ser_valid=1. ser_out = shift[0] when MSB_FIRST=0, or shift[N-1] when MSB_FIRST=1.
- Transfer: a beat completes on an edge with ser_valid and ser_ready both high. The shift register then shifts one position toward the output end (zero fill) and the counter increments.
- Backpressure: with ser_ready=0, ser_out, ser_last and the counter hold for any number of cycles.
- ser_last=1 when counter == BEATS-1. BEATS = N, or N+1 with the optional feature.
- Frame end: the edge that accepts a beat with ser_last=1 returns the FSM to IDLE. in_ready rises the next cycle. There is one mandatory idle cycle between frames; no same-edge reload.
- Latency: word accepted at edge k → first bit valid in the cycle after edge k. With ser_ready held high, a frame occupies BEATS cycles plus 1 idle cycle.
- in_valid during SHIFT is ignored; in_data is not sampled.
- Counter width: $clog2(N+2) bits. It must not wrap within a frame.
- N=1: the first bit is also the last; ser_last=1 on the first beat.
- aclr asserted mid-frame: the frame is aborted and the partial word discarded. All outputs return to reset values asynchronously. No stale bits are emitted after release.

Optional Feature:
- Macro: PAR_TO_SER_PARITY_EN.
- Defined: one even-parity bit (XOR of the loaded word, computed at load) is appended after the N data bits. BEATS=N+1. ser_last is asserted on the parity beat only.
- Undefined: no parity logic or register. BEATS=N. ser_last is asserted on data bit N-1 (in send order).

Decomposition:
- Shared package par_to_ser_pkg holds:
  - typedef enum logic {IDLE, SHIFT} tx_state_t;
  - function for counter width;
  - localparam for parity beat count.
- Sub-module shift_reg_aclr: N-bit loadable shift register with async active-high clear, ports (clock, aclr, load, shift, dir, d, q). The top level holds the FSM, counter and parity.

Test Plan:
- Reset values: drive aclr=1 while in_valid=1 → in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0; nothing is loaded.
- Basic frame: N=8, MSB_FIRST=0, ser_ready=1, load 8'hA5 → ser_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_last only on the 8th; in_ready=1 on the following cycle.
- Backpressure: load 8'h3C, drop ser_ready for 3 cycles after beat 2 → ser_out holds 1 and ser_last holds 0 through the stall; full sequence 0,0,1,1,1,1,0,0 is still delivered.
- Ignored input and MSB order: MSB_FIRST=1, load 8'h81, then drive in_valid=1 with 8'hFF during SHIFT → output 1,0,0,0,0,0,0,1; the second word is accepted only after the idle cycle.
- Mid-frame reset: pulse aclr after beat 4 of 8'hF0 → ser_valid=0 immediately; after release in_ready=1; the next word 8'h01 transmits cleanly.
- Parity (PAR_TO_SER_PARITY_EN defined): 8'h07 → 9 beats 1,1,1,0,0,0,0,0,1; ser_last on beat 9. Repeat with 8'h03 → parity bit 0.
